// File: rtl/i2c_master_txn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_txn : single-byte I2C master (START/addr/ACK/data/ACK/STOP)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_master_txn #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_ADDR  = 3'd2;
  localparam logic [2:0] c_AACK  = 3'd3;
  localparam logic [2:0] c_DATA  = 3'd4;
  localparam logic [2:0] c_DACK  = 3'd5;
  localparam logic [2:0] c_STOP  = 3'd6;
  localparam logic [2:0] c_DONE  = 3'd7;

  localparam logic [7:0] c_QMAX = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       rw_q, rw_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tick;

  assign tick = (qcnt_q == c_QMAX);

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bitcnt_d  = bitcnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    wbyte_d   = wbyte_q;
    rw_d      = rw_q;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q != c_IDLE && state_q != c_DONE) begin
      qcnt_d = tick ? 8'd0 : qcnt_q + 8'd1;
    end

    case (state_q)
      c_IDLE: begin
        if (start) begin
          tx_d      = {addr, rw};
          rx_d      = 8'h00;
          wbyte_d   = wdata;
          rw_d      = rw;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          qcnt_d    = 8'd0;
          phase_d   = 2'd0;
          bitcnt_d  = 3'd0;
          state_d   = c_START;
        end
      end
      c_START: begin
        if (tick) begin
          if (phase_q == 2'd1) begin
            phase_d = 2'd0;
            state_d = c_ADDR;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      c_ADDR, c_DATA: begin
        if (tick) begin
          if (phase_q == 2'd2 && state_q == c_DATA && rw_q) begin
            rx_d = {rx_q[6:0], sda_in};
          end
          if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            tx_d    = {tx_q[6:0], 1'b0};
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = 3'd0;
              state_d  = (state_q == c_ADDR) ? c_AACK : c_DACK;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      c_AACK: begin
        if (tick) begin
          if (phase_q == 2'd2 && sda_in) begin
            ack_err_d = 1'b1;
          end
          if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            if (ack_err_q) begin
              state_d = c_STOP;
            end else begin
              tx_d    = wbyte_q;
              state_d = c_DATA;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      c_DACK: begin
        if (tick) begin
          if (phase_q == 2'd2 && sda_in && !rw_q) begin
            ack_err_d = 1'b1;
          end
          if (phase_q == 2'd3) begin
            phase_d = 2'd0;
            state_d = c_STOP;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      c_STOP: begin
        if (tick) begin
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = c_DONE;
            if (rw_q) begin
              rdata_d = rx_q;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Line enables are derived from the upcoming state so they register cleanly.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      c_START: begin
        scl_oe_d = (phase_d == 2'd1);
        sda_oe_d = 1'b1;
      end
      c_ADDR: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = ~tx_d[7];
      end
      c_AACK, c_DACK: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = 1'b0;
      end
      c_DATA: begin
        scl_oe_d = ~phase_d[1];
        sda_oe_d = rw_d ? 1'b0 : ~tx_d[7];
      end
      c_STOP: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd2);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= c_IDLE;
      qcnt_q    <= 8'd0;
      phase_q   <= 2'd0;
      bitcnt_q  <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      wbyte_q   <= 8'h00;
      rw_q      <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bitcnt_q  <= bitcnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      wbyte_q   <= wbyte_d;
      rw_q      <= rw_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_txn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_master_txn : bench with an I2C target model observing the lines   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_i2c_master_txn;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Target model configuration and observation log
  logic       tgt_ack_addr = 1'b1;
  logic       tgt_ack_data = 1'b1;
  logic [7:0] tgt_rd_byte  = 8'h00;
  logic       tgt_pull     = 1'b0;
  logic       bits [0:31];
  int         nbits   = 0;
  int         n_start = 0;
  int         n_stop  = 0;
  logic       scl_prev = 1'b1;
  logic       sda_prev = 1'b1;
  logic       scl_now, sda_now;
  int         k;

  logic [7:0] rdata_exp = 8'h00;

  i2c_master_txn #(.CLK_DIV(CLK_DIV)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_in = ~(sda_oe | tgt_pull);

  // Target: decodes bits on SCL rising edges, changes its drive only while SCL is low
  always @(negedge clk) begin
    scl_now = ~scl_oe;
    sda_now = ~(sda_oe | tgt_pull);
    if (!rst_n) begin
      tgt_pull = 1'b0;
    end else begin
      if (scl_prev && scl_now && sda_prev && !sda_now) n_start++;
      if (scl_prev && scl_now && !sda_prev && sda_now) n_stop++;
      if (!scl_prev && scl_now) begin
        if (nbits < 32) bits[nbits] = sda_now;
        nbits++;
      end
      if (scl_prev && !scl_now) begin
        k = nbits;
        tgt_pull = 1'b0;
        if (k == 8)
          tgt_pull = tgt_ack_addr;
        else if (k >= 9 && k <= 16 && bits[7] && tgt_ack_addr)
          tgt_pull = ~tgt_rd_byte[16-k];
        else if (k == 17 && !bits[7])
          tgt_pull = tgt_ack_data;
      end
    end
    scl_prev = scl_now;
    sda_prev = ~(sda_oe | tgt_pull);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one command; called at #1 after a clock edge.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic [7:0] rb, input logic aa, input logic ad,
                         input bit inj, input int rst_at, input int exp_wait,
                         input string tag);
    int waits, e0, t, t_done, guard, exp_lat;
    bit done_seen, rst_hit, busy_drop;
    logic [7:0] abyte, dbyte;

    tgt_ack_addr = aa;
    tgt_ack_data = ad;
    tgt_rd_byte  = rb;
    nbits = 0; n_start = 0; n_stop = 0;
    addr = a; rw = r; wdata = wd; start = 1'b1;

    waits = 0;
    while (waits < 4 && !busy) begin
      @(posedge clk); #1;
      waits++;
      if (waits == 1 && exp_wait == 2) chk({tag, "_start_in_done"}, {30'd0, busy, done}, 32'd0);
    end
    start = 1'b0;
    if (!busy) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    e0 = cyc;
    chk({tag, "_accept_edge"}, waits, exp_wait);
    chk({tag, "_start_q0"}, {30'd0, scl_oe, sda_oe}, 32'b01);

    exp_lat = (aa ? 77 : 41) * CLK_DIV;
    done_seen = 0; rst_hit = 0; busy_drop = 0; guard = 0; t_done = 0;
    while (!done_seen && !rst_hit && guard < 100 * CLK_DIV) begin
      @(posedge clk); #1;
      guard++;
      t = cyc - e0;
      if (rst_at > 0 && t == rst_at) begin
        chk({tag, "_rst_outputs"}, {19'd0, busy, done, ack_err, scl_oe, sda_oe, rdata},
            32'd0);
        rst_n = 1'b1;
        rst_hit = 1;
        rdata_exp = 8'h00;
      end else if (done) begin
        done_seen = 1;
        t_done = t;
      end else if (!busy) begin
        busy_drop = 1;
      end
      if (inj && t == 49) begin
        start = 1'b1; addr = ~a; wdata = ~wd; rw = ~r;
      end
      if (inj && t == 50) start = 1'b0;
      if (rst_at > 0 && t == rst_at - 1) rst_n = 1'b0;
    end
    if (rst_hit) return;
    if (!done_seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end

    if (r && aa) rdata_exp = rb;
    for (int i = 0; i < 8; i++) begin
      abyte[7-i] = bits[i];
      dbyte[7-i] = bits[9+i];
    end

    chk({tag, "_done_latency"}, t_done, exp_lat);
    chk({tag, "_busy_held"}, {31'd0, busy_drop}, 32'd0);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ack_err"}, {31'd0, ack_err}, {31'd0, (!aa || (!r && !ad))});
    chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, rdata_exp});
    chk({tag, "_addr_byte"}, {24'd0, abyte}, {24'd0, a, r});
    chk({tag, "_addr_ack_bit"}, {31'd0, bits[8]}, {31'd0, ~aa});
    chk({tag, "_nbits"}, nbits, aa ? 19 : 10);
    chk({tag, "_start_cnt"}, n_start, 1);
    chk({tag, "_stop_cnt"}, n_stop, 1);
    if (aa) begin
      chk({tag, "_data_byte"}, {24'd0, dbyte}, {24'd0, (r ? rb : wd)});
      chk({tag, "_data_ack_bit"}, {31'd0, bits[17]}, {31'd0, (r ? 1'b1 : ~ad)});
      chk({tag, "_stop_scl_rise"}, {31'd0, bits[18]}, 32'd0);
    end else begin
      chk({tag, "_nack_stop_rise"}, {31'd0, bits[9]}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] a;
    logic [7:0] wd, rb;
    logic       r, aa, ad;

    rst_n = 1'b0; start = 1'b1; rw = 1'b1; addr = 7'h7F; wdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", {20'd0, busy, done, scl_oe, sda_oe, rdata}, 32'd0);
    end
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("reset_release", {20'd0, busy, done, scl_oe, sda_oe, rdata}, 32'd0);

    run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1, "write");
    run_txn(7'h3C, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b1, 1'b0, 0, 2, "read_b2b");
    idle(2);
    run_txn(7'h21, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1, "addr_nack");
    idle(2);
    run_txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1, "start_ignored");
    idle(2);
    run_txn(7'h12, 1'b0, 8'h34, 8'h00, 1'b1, 1'b1, 1'b0, 120, 1, "mid_reset");
    @(posedge clk); #1;
    chk("post_reset_idle", {29'd0, busy, done, scl_oe}, 32'd0);
    run_txn(7'h12, 1'b0, 8'h34, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1, "after_reset");

    for (int i = 0; i < 20; i++) begin
      a  = 7'($urandom);
      r  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      rb = 8'($urandom);
      aa = r ? 1'b1 : ($urandom_range(0, 3) != 0);
      ad = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        run_txn(a, r, wd, rb, aa, ad, 1'b0, 0, 2, "rand_b2b");
      end else begin
        idle($urandom_range(1, 4));
        run_txn(a, r, wd, rb, aa, ad, 1'b0, 0, 1, "rand");
      end
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_master_txn.md
# i2c_master_txn

Single-byte I2C master transaction engine that sits directly upstream of the I2C pads in the tt_um_I2C design. It accepts a command (7-bit address, R/W, write byte) from the top-level control logic and drives open-drain SCL/SDA enables through START, address, ACK, data, ACK and STOP. It returns a completion pulse, an ACK-error flag and the read byte.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period. Legal range 2..255. The SCL period is 4*CLK_DIV cycles.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  command strobe. Sampled only in IDLE.
- rw  in  1  0 = write, 1 = read. Captured with start.
- addr  in  7  target address. Captured with start.
- wdata  in  8  write byte. Captured with start.
- busy  out  1  high from the start-accept edge until the done edge (exclusive).
- done  out  1  single-cycle completion pulse.
- ack_err  out  1  NACK seen on the address or write-data ACK slot. Valid with done; held until the next accepted start.
- rdata  out  8  read byte. Updated on done for reads only; held otherwise.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  sampled SDA line, already synchronised externally.

## Operation
- Reset values: busy=0, done=0, ack_err=0, rdata=0x00, scl_oe=0, sda_oe=0, state=IDLE, all counters 0.
- States: IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE.
- IDLE: both lines released. When start=1, capture {addr,rw} as shift byte, wdata and rw; clear ack_err; set busy; go to START.
- START, 2 quarters:
  - q0: scl_oe=0, sda_oe=1 (SDA falls while SCL is high).
  - q1: scl_oe=1, sda_oe=1.
- Bit slot, 4 quarters, used by ADDR, AACK, DATA and DACK:
  - q0–q1: scl_oe=1. SDA is updated at the start of q0.
  - q2–q3: scl_oe=0.
  - sda_in is sampled on the last clk of q2.
- ADDR: 8 bits, MSB first: addr[6:0] then rw. sda_oe = ~bit.
- AACK: sda_oe=0, sample sda_in. If 1, set ack_err and go to STOP; if 0, go to DATA.
- DATA:
  - Write: shift wdata MSB first, sda_oe = ~bit.
  - Read: sda_oe=0; shift sda_in into an internal shift register MSB first.
- DACK:
  - Write: sda_oe=0; sample sda_in; set ack_err if it is 1.
  - Read: master sends NACK, sda_oe=0.
  - Go to STOP in both cases.
- STOP, 3 quarters:
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0, sda_oe=1.
  - q2: scl_oe=0, sda_oe=0.
- DONE: lasts one cycle. done=1, busy=0; on reads, rdata is loaded from the shift register. Next state is IDLE.
- No clock stretching and no arbitration. SCL is never sampled.
- start while busy: ignored; captured fields stay unchanged.
- start high in the DONE cycle: ignored. start high in the IDLE cycle that follows: accepted.
- rst_n low at any point, including mid-transaction: all outputs return to reset values on that edge. No STOP is generated.

## Timing
- Quarter counter counts 0..CLK_DIV-1. Phases advance when it wraps.
- Define E0 as the edge on which start is accepted.
  - busy=1 and the START q0 line values are in effect from E0.
  - Full transaction (read or write, no address NACK): 2 + 36 + 36 + 3 = 77 quarters. The DONE edge is E0 + 77*CLK_DIV.
  - Address NACK: 2 + 36 + 3 = 41 quarters. The DONE edge is E0 + 41*CLK_DIV.
- scl_oe and sda_oe are registered outputs with no combinational path from inputs.
- Back-to-back commands: the earliest re-accept is the edge after DONE, so a minimum of 1 IDLE cycle separates transactions.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1. Required: busy=0, done=0, scl_oe=0, sda_oe=0, rdata=0x00 throughout and 1 cycle after release.
- Write, CLK_DIV=4: addr=0x50, rw=0, wdata=0xA5, with an ACKing target model. Required:
  - the bit stream decoded on SCL rising edges is 0xA0, ACK, 0xA5, ACK;
  - START and STOP are correctly formed;
  - done occurs at E0+308 with ack_err=0.
- Read: addr=0x3C, rw=1, target model returns 0xC3. Required: rdata=0xC3 on the done edge, ack_err=0, master NACKs the data byte, done at E0+308.
- Address NACK: the model does not ACK. Required: ack_err=1 on done, done at E0+164, no DATA slot generated.
- start pulsed at E0+50 during a write. Required: ignored; the byte sent is unchanged and done still occurs at E0+308.
- rst_n=0 at E0+120. Required: the next edge shows scl_oe=0, sda_oe=0, busy=0, no done. A fresh start afterwards completes normally.
